nanosoc_uart_rx_to_axi_stream_8: RTL and testbench
==================================================

// Module: nanosoc_uart_rx_to_axi_stream_8
// PURPOSE
//  Synthesizable async-serial (8N1) receiver. Deserialises one UART line into an 8-bit
//  AXI-stream byte channel, buffered by a small FIFO.
//  Sits directly upstream of the rxd8 stream sink/logger. Feeds its rxd8_valid/ready/data.
//  Lets ADP/UART serial traffic be captured as a byte stream, in simulation or on FPGA.
// PARAMETERS
//  CLKS_PER_BIT  16  aclk cycles per serial bit; even, >= 4
//  FIFO_DEPTH    4   output buffer entries; power of 2, >= 2
// PORTS
//  aclk           in   1  clock, rising edge
//  areset         in   1  asynchronous, active-high reset
//  rxd            in   1  serial line, idle high, asynchronous to aclk
//  rxd8_ready     in   1  downstream ready
//  rxd8_valid     out  1  byte available at FIFO head
//  rxd8_data      out  8  FIFO head byte
//  frame_err      out  1  1-cycle pulse: stop bit sampled low
//  overrun_err    out  1  1-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
//  Reset values
//   - rxd8_valid=0, rxd8_data=0, frame_err=0, overrun_err=0.
//   - FIFO empty; FSM in ARM; synchroniser flops =1.
//  Input sync: rxd passes through 2 flops (rxd_s) before any use.
//  FSM states and transitions
//   - ARM: rxd_s must be high for CLKS_PER_BIT consecutive cycles, then -> IDLE.
//     Any low restarts the count. Prevents false start after reset mid-frame.
//   - IDLE: on rxd_s 1->0, load baud counter with CLKS_PER_BIT/2-1 -> START.
//   - START: at counter expiry sample rxd_s.
//     Low: -> DATA, bit_idx=0, counter=CLKS_PER_BIT-1.
//     High: glitch; -> IDLE, no error.
//   - DATA: sample every CLKS_PER_BIT cycles, mid-bit, LSB first into shift reg.
//     After bit_idx==7 -> STOP.
//   - STOP: sample at mid-bit.
//     High: push byte -> IDLE.
//     Low: frame_err pulse, byte discarded -> ARM (waits out break/low line).
//  Push/pop rules
//   - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
//   - Otherwise the byte is dropped and overrun_err pulses the same cycle.
//   - Earlier FIFO contents stay intact on overrun.
//  Latency: byte visible on rxd8_valid/rxd8_data the cycle after the stop-bit sample cycle.
//  Handshake
//   - Pop when rxd8_valid && rxd8_ready.
//   - While valid && !ready, rxd8_data is held stable.
//   - valid never drops without a pop.
//  Data is unchanged: all 256 values pass through, including 0x04.
//  Widths
//   - Baud counter: $clog2(CLKS_PER_BIT) bits, decrement to 0.
//   - bit_idx: 3 bits.
//   - FIFO pointers: $clog2(FIFO_DEPTH)+1 bits, wrap naturally; full when MSBs differ.
//  Reset mid-frame: partial byte lost; FIFO flushed; no error pulses generated.
// STRUCTURE
//  - nanosoc_uart_defs.vh: FSM state localparams (ARM, IDLE, START, DATA, STOP),
//    frame constants (DATA_BITS=8).
//  - Sub-module nanosoc_stream_fifo_8: sync FIFO, ports aclk/areset,
//    push/push_data/full, pop/head_data/empty.
//  - Top: synchroniser, baud counter, FSM, shift register, error pulses.
// TESTING  (CLKS_PER_BIT=16, FIFO_DEPTH=4)
//  1. Frame 0x41, ready=1 -> one rxd8_valid beat, data=0x41, ~152+3 clk after start edge.
//     No error pulses.
//  2. rxd low for 4 clk then high -> no valid, no frame_err; next frame 0x5A received correctly.
//  3. Frame 0x55 with stop bit low -> frame_err 1 pulse, no valid.
//     Following 0xA3 (after 16 idle high clk) received.
//  4. ready=0, send 0x01..0x05 -> 4 entries held, overrun_err on 5th.
//     Then ready=1 drains 01,02,03,04 in order.
//  5. Back-to-back 0x48,0x04 to downstream logger -> both passed through;
//     logger sees 0x04 and terminates.
//  6. areset mid-DATA of 0x7E with rxd held low 40 clk after release -> no output, no errors.
//     Next full frame 0x33 received.

Source files
------------

// File: rtl/nanosoc_uart_rx_to_axi_stream_8_pkg.sv
// nanosoc_uart_rx_to_axi_stream_8_pkg: shared frame constants and receiver FSM states
package nanosoc_uart_rx_to_axi_stream_8_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/nanosoc_stream_fifo_8.sv
// nanosoc_stream_fifo_8: synchronous byte FIFO with show-ahead head and pop-while-full push
module nanosoc_stream_fifo_8
  import nanosoc_uart_rx_to_axi_stream_8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  output logic                 full,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] head_data,
  output logic                 empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic wr, rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign head_data = empty ? '0 : mem[rp[AW-1:0]];
  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
  // storage write; a full FIFO popped this cycle reuses the slot being vacated
  always_ff @(posedge aclk) begin
    if (wr) mem[wp[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/nanosoc_uart_rx_to_axi_stream_8.sv
// nanosoc_uart_rx_to_axi_stream_8: 8N1 UART receiver feeding a buffered byte stream
module nanosoc_uart_rx_to_axi_stream_8
  import nanosoc_uart_rx_to_axi_stream_8_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       rxd,
  input  logic       rxd8_ready,
  output logic       rxd8_valid,
  output logic [7:0] rxd8_data,
  output logic       frame_err,
  output logic       overrun_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  logic [1:0] sync;
  logic rxd_s, rxd_q, tick, push, full, empty;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  assign rxd_s = sync[1];
  assign tick = cnt == '0;
  assign rxd8_valid = !empty;
  assign overrun_err = push && full && !rxd8_ready;
  // two-flop synchroniser plus delayed copy for start-edge detection
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync <= 2'b11;
      rxd_q <= 1'b1;
    end else begin
      sync <= {sync[0], rxd};
      rxd_q <= rxd_s;
    end
  end
  // receiver state, baud counter, bit index and shift register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ARM;
      cnt <= FULL_BIT;
      idx <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
    end
  end
  // next state: ARM waits for a full bit time of idle line so a frame cut by reset is not mistaken for a start
  always_comb begin
    state_n = state;
    cnt_n = tick ? FULL_BIT : cnt - 1'b1;
    idx_n = idx;
    sh_n = sh;
    push = 1'b0;
    frame_err = 1'b0;
    case (state)
      ARM: begin
        if (!rxd_s) cnt_n = FULL_BIT;
        else if (tick) state_n = IDLE;
      end
      IDLE: begin
        cnt_n = HALF_BIT;
        if (rxd_q && !rxd_s) state_n = START;
      end
      START: begin
        if (tick) begin
          state_n = rxd_s ? IDLE : DATA;
          idx_n = '0;
        end
      end
      DATA: begin
        if (tick) begin
          sh_n = {rxd_s, sh[DATA_BITS-1:1]};
          idx_n = idx + 1'b1;
          if (idx == 3'(DATA_BITS - 1)) state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          push = rxd_s;
          frame_err = !rxd_s;
          state_n = rxd_s ? IDLE : ARM;
        end
      end
      default: state_n = ARM;
    endcase
  end
  nanosoc_stream_fifo_8 #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (push),
    .push_data (sh),
    .full      (full),
    .pop       (rxd8_ready),
    .head_data (rxd8_data),
    .empty     (empty)
  );
endmodule

// File: tb/tb_nanosoc_uart_rx_to_axi_stream_8.sv
// tb_nanosoc_uart_rx_to_axi_stream_8: scoreboard bench for the UART-to-stream receiver
module tb_nanosoc_uart_rx_to_axi_stream_8;
  localparam int CPB = 16;
  localparam int DEPTH = 4;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic rxd = 1'b1;
  logic rxd8_ready = 1'b1;
  logic rxd8_valid, frame_err, overrun_err;
  logic [7:0] rxd8_data;
  int total = 0, passed = 0;
  int fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
  logic [7:0] exp_q[$];
  bit rand_ready = 0;

  nanosoc_uart_rx_to_axi_stream_8 #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .rxd         (rxd),
    .rxd8_ready  (rxd8_ready),
    .rxd8_valid  (rxd8_valid),
    .rxd8_data   (rxd8_data),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_frame(logic [7:0] d, logic stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
  endtask

  // model: a good byte is kept if fewer than DEPTH bytes are still waiting, else it is an overrun
  task automatic send_good(logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else ov_exp++;
    send_frame(d, 1'b1);
  endtask

  task automatic send_bad(logic [7:0] d);
    fe_exp++;
    send_frame(d, 1'b0);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // monitor: compares every accepted beat against the scoreboard and counts error pulses
  always @(negedge aclk) begin
    if (!areset) begin
      if (frame_err) fe_seen++;
      if (overrun_err) ov_seen++;
      if (rxd8_valid && rxd8_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_byte: got %02h want none", rxd8_data);
        end else check("rx_byte", rxd8_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rand_ready) rxd8_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] d;
    tick(3);
    check("reset_valid", rxd8_valid, 0);
    check("reset_data", rxd8_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun_err", overrun_err, 0);
    areset = 1'b0;
    tick(CPB + 4);
    exp_q.push_back(8'h41);
    n = 0;
    fork
      send_frame(8'h41, 1'b1);
      begin
        while (!rxd8_valid && n < 400) begin
          @(negedge aclk);
          n++;
        end
      end
    join
    check("t1_latency_in_range", 32'(n >= 150 && n <= 160), 1);
    tick(20);
    wait_drain("t1_drain");
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(30);
    send_good(8'h5A);
    tick(20);
    wait_drain("t2_drain");
    check("t2_no_frame_err", fe_seen, 0);
    send_bad(8'h55);
    tick(16);
    send_good(8'hA3);
    tick(20);
    wait_drain("t3_drain");
    check("t3_frame_err", fe_seen, fe_exp);
    rxd8_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_good(8'(i));
      tick(4);
    end
    check("t4_overrun", ov_seen, ov_exp);
    check("t4_head_valid", rxd8_valid, 1);
    check("t4_head_data", rxd8_data, 8'h01);
    rxd8_ready = 1'b1;
    wait_drain("t4_drain");
    send_good(8'h48);
    send_good(8'h04);
    tick(20);
    wait_drain("t5_drain");
    d = 8'h7E;
    rxd = 1'b0;
    tick(CPB);
    rxd = d[0];
    tick(CPB);
    rxd = d[1];
    tick(CPB / 2);
    areset = 1'b1;
    tick(2);
    check("t6_reset_valid", rxd8_valid, 0);
    areset = 1'b0;
    rxd = 1'b0;
    tick(40);
    rxd = 1'b1;
    tick(20);
    send_good(8'h33);
    tick(20);
    wait_drain("t6_drain");
    check("t6_frame_err", fe_seen, fe_exp);
    rand_ready = 1;
    repeat (24) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        send_bad(d);
        tick(16 + $urandom_range(0, 8));
      end else begin
        send_good(d);
        tick($urandom_range(0, 12));
      end
    end
    rand_ready = 0;
    tick(1);
    rxd8_ready = 1'b1;
    tick(20);
    wait_drain("rand_drain");
    check("final_frame_err", fe_seen, fe_exp);
    check("final_overrun_err", ov_seen, ov_exp);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
